// File: rtl/i_ddr_deser_align.sv
// i_ddr_deser_align: multi-lane DDR deserializer with per-lane
// training-word bit alignment (slip search, lock and fail detection).
module i_ddr_deser_align #(
    parameter int                 LANES         = 2,
    parameter int                 RATIO         = 4,
    parameter logic [2*RATIO-1:0] TRAIN_PATTERN = 8'hB4,
    parameter int                 LOCK_COUNT    = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic [LANES-1:0]                      din_rise,
    input  logic [LANES-1:0]                      din_fall,
    input  logic                                  align_start,
    output logic [LANES*2*RATIO-1:0]              dout,
    output logic                                  dout_valid,
    output logic [LANES-1:0]                      locked,
    output logic [LANES-1:0]                      align_fail,
    output logic [LANES*$clog2(2*RATIO)-1:0]      slip_offset
);

    localparam int W  = 2 * RATIO;
    localparam int OW = $clog2(W);
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int SW = $clog2(W + 1);

    typedef enum logic [2:0] {IDLE, CHECK, SLIP, LOCKED, FAIL} state_t;

    logic [2*W-1:0] hist_q   [LANES];
    logic [2*W-1:0] hist_nxt [LANES];
    logic [CW-1:0]  cnt_q;
    logic           strobe;

    state_t         st_q   [LANES];
    state_t         st_d   [LANES];
    logic [OW-1:0]  off_q  [LANES];
    logic [OW-1:0]  off_d  [LANES];
    logic [MW-1:0]  mcnt_q [LANES];
    logic [MW-1:0]  mcnt_d [LANES];
    logic [SW-1:0]  scnt_q [LANES];
    logic [SW-1:0]  scnt_d [LANES];
    logic [1:0]     disc_q [LANES];
    logic [1:0]     disc_d [LANES];

    assign strobe = enable && (cnt_q == CW'(RATIO - 1));

    // Newest pair enters at the LSB end; the rise bit is the older one.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            hist_nxt[i] = {hist_q[i][2*W-3:0], din_rise[i], din_fall[i]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            cnt_q      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            dout_valid <= strobe;
            if (enable) begin
                cnt_q <= strobe ? '0 : cnt_q + 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    hist_q[i] <= hist_nxt[i];
                end
            end
            if (strobe) begin
                for (int i = 0; i < LANES; i++) begin
                    dout[i*W +: W] <= hist_nxt[i][off_q[i] +: W];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LANES; i++) begin
            if (reset) begin
                st_q[i]   <= IDLE;
                off_q[i]  <= '0;
                mcnt_q[i] <= '0;
                scnt_q[i] <= '0;
                disc_q[i] <= '0;
            end else begin
                st_q[i]   <= st_d[i];
                off_q[i]  <= off_d[i];
                mcnt_q[i] <= mcnt_d[i];
                scnt_q[i] <= scnt_d[i];
                disc_q[i] <= disc_d[i];
            end
        end
    end

    // disc 0 = slip still pending, 1..2 = discarding words after the slip.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            st_d[i]   = st_q[i];
            off_d[i]  = off_q[i];
            mcnt_d[i] = mcnt_q[i];
            scnt_d[i] = scnt_q[i];
            disc_d[i] = disc_q[i];
            if (align_start) begin
                st_d[i]   = CHECK;
                off_d[i]  = '0;
                mcnt_d[i] = '0;
                scnt_d[i] = '0;
                disc_d[i] = '0;
            end else begin
                unique case (st_q[i])
                    CHECK: begin
                        if (dout_valid) begin
                            if (dout[i*W +: W] == TRAIN_PATTERN) begin
                                mcnt_d[i] = mcnt_q[i] + 1'b1;
                                if (mcnt_q[i] == MW'(LOCK_COUNT - 1)) begin
                                    st_d[i] = LOCKED;
                                end
                            end else begin
                                mcnt_d[i] = '0;
                                disc_d[i] = '0;
                                st_d[i]   = SLIP;
                            end
                        end
                    end
                    SLIP: begin
                        if (disc_q[i] == 2'd0) begin
                            if (enable) begin
                                off_d[i]  = (off_q[i] == OW'(W - 1)) ? '0 : off_q[i] + 1'b1;
                                scnt_d[i] = scnt_q[i] + 1'b1;
                                disc_d[i] = 2'd1;
                                if (scnt_q[i] == SW'(W - 1)) begin
                                    st_d[i] = FAIL;
                                end
                            end
                        end else if (dout_valid) begin
                            if (disc_q[i] == 2'd2) begin
                                disc_d[i] = 2'd0;
                                st_d[i]   = CHECK;
                            end else begin
                                disc_d[i] = disc_q[i] + 1'b1;
                            end
                        end
                    end
                    IDLE, LOCKED, FAIL: begin
                    end
                    default: st_d[i] = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        locked      = '0;
        align_fail  = '0;
        slip_offset = '0;
        for (int i = 0; i < LANES; i++) begin
            locked[i]               = (st_q[i] == LOCKED);
            align_fail[i]           = (st_q[i] == FAIL);
            slip_offset[i*OW +: OW] = off_q[i];
        end
    end

endmodule

// File: tb/tb_i_ddr_deser_align.sv
// tb_i_ddr_deser_align: random DDR streams checked against a word-level
// model of the deserializer and its per-lane alignment search.
module tb_i_ddr_deser_align;

    localparam int LANES = 2;
    localparam int RATIO = 4;
    localparam int W     = 8;
    localparam int LOCKN = 4;
    localparam int SZ    = 16384;
    localparam logic [7:0] PAT = 8'hB4;

    localparam int M_IDLE  = 0;
    localparam int M_CHECK = 1;
    localparam int M_DISC  = 2;
    localparam int M_LOCK  = 3;
    localparam int M_DEAD  = 4;

    logic        clk_i = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  din_rise;
    logic [1:0]  din_fall;
    logic        align_start;
    logic [15:0] dout;
    logic        dout_valid;
    logic [1:0]  locked;
    logic [1:0]  align_fail;
    logic [5:0]  slip_offset;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    i_ddr_deser_align #(
        .LANES(LANES), .RATIO(RATIO), .TRAIN_PATTERN(PAT), .LOCK_COUNT(LOCKN)
    ) dut (
        .clk_i(clk_i), .reset(reset), .enable(enable),
        .din_rise(din_rise), .din_fall(din_fall), .align_start(align_start),
        .dout(dout), .dout_valid(dout_valid), .locked(locked),
        .align_fail(align_fail), .slip_offset(slip_offset)
    );

    // Stimulus sources: 0 random table, 1 training pattern, 2 all zero
    int mode [LANES];
    int dly  [LANES];
    int gp = 0;
    bit rnd  [LANES][SZ];

    // Reference model: bit history, word phase, per-lane search state
    bit          mh [LANES][SZ];
    int          mn = 0;
    int          mbase = 0;
    int          mph = 0;
    logic        exp_valid = 1'b0;
    logic [15:0] exp_dout = '0;
    int          ms    [LANES];
    int          moff  [LANES];
    int          mmat  [LANES];
    int          mslip [LANES];
    int          mleft [LANES];

    function automatic logic [7:0] word_at(input int l, input int k);
        logic [7:0] w;
        int idx;
        for (int j = 0; j < W; j++) begin
            idx = mn - 1 - k - W + 1 + j;
            w[W-1-j] = (idx < mbase) ? 1'b0 : mh[l][idx % SZ];
        end
        return w;
    endfunction

    task automatic judge(input int l, input logic [7:0] w);
        case (ms[l])
            M_CHECK: begin
                if (w == PAT) begin
                    mmat[l]++;
                    if (mmat[l] == LOCKN) ms[l] = M_LOCK;
                end else begin
                    mmat[l]  = 0;
                    mslip[l]++;
                    moff[l]  = (moff[l] + 1) % W;
                    mleft[l] = 2;
                    ms[l]    = (mslip[l] == W) ? M_DEAD : M_DISC;
                end
            end
            M_DISC: begin
                mleft[l]--;
                if (mleft[l] == 0) ms[l] = M_CHECK;
            end
            default: ;
        endcase
    endtask

    always @(posedge clk_i) begin
        logic        nv;
        logic [15:0] nd;
        if (reset) begin
            mbase     = mn;
            mph       = 0;
            exp_valid = 1'b0;
            exp_dout  = '0;
            for (int l = 0; l < LANES; l++) begin
                ms[l] = M_IDLE; moff[l] = 0; mmat[l] = 0;
                mslip[l] = 0; mleft[l] = 0;
            end
        end else begin
            nv = 1'b0;
            nd = exp_dout;
            if (enable) begin
                for (int l = 0; l < LANES; l++) begin
                    mh[l][mn % SZ]       = din_rise[l];
                    mh[l][(mn + 1) % SZ] = din_fall[l];
                end
                mn += 2;
                mph++;
                if (mph == RATIO) begin
                    mph = 0;
                    nv  = 1'b1;
                    for (int l = 0; l < LANES; l++) nd[l*W +: W] = word_at(l, moff[l]);
                end
            end
            if (align_start) begin
                for (int l = 0; l < LANES; l++) begin
                    ms[l] = M_CHECK; moff[l] = 0; mmat[l] = 0;
                    mslip[l] = 0; mleft[l] = 0;
                end
            end else if (exp_valid) begin
                for (int l = 0; l < LANES; l++) judge(l, exp_dout[l*W +: W]);
            end
            exp_valid = nv;
            exp_dout  = nd;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
        chk("dout", 32'(dout), 32'(exp_dout));
        if (exp_valid) begin
            for (int l = 0; l < LANES; l++) begin
                chk("locked", 32'(locked[l]), 32'(ms[l] == M_LOCK));
                chk("align_fail", 32'(align_fail[l]), 32'(ms[l] == M_DEAD));
                chk("slip_offset", 32'(slip_offset[l*3 +: 3]), 32'(moff[l]));
            end
        end
    endtask

    task automatic step();
        logic [7:0] pv;
        logic en_s, rs_s;
        pv = PAT;
        for (int l = 0; l < LANES; l++) begin
            case (mode[l])
                1: begin
                    din_rise[l] = pv[7 - ((gp + dly[l]) % 8)];
                    din_fall[l] = pv[7 - ((gp + 1 + dly[l]) % 8)];
                end
                2: begin
                    din_rise[l] = 1'b0;
                    din_fall[l] = 1'b0;
                end
                default: begin
                    din_rise[l] = rnd[l][gp % SZ];
                    din_fall[l] = rnd[l][(gp + 1) % SZ];
                end
            endcase
        end
        en_s = enable;
        rs_s = reset;
        @(posedge clk_i);
        #1;
        if (rs_s) gp = 0;
        else if (en_s) gp += 2;
        compare();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " dout"}, 32'(dout), 32'd0);
        chk({tag, " dout_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, " locked"}, 32'(locked), 32'd0);
        chk({tag, " align_fail"}, 32'(align_fail), 32'd0);
        chk({tag, " slip_offset"}, 32'(slip_offset), 32'd0);
    endtask

    initial begin
        int nv, s0, s1, lockw, wsince, bad, lastv, found, gv;
        bit lk0;
        logic [2:0] p0, p1;
        logic [7:0] ew;

        for (int l = 0; l < LANES; l++) begin
            mode[l] = 0;
            dly[l]  = 0;
            for (int i = 0; i < SZ; i++) rnd[l][i] = 1'($urandom);
        end
        reset = 1'b1; enable = 1'b0; align_start = 1'b0;
        din_rise = '0; din_fall = '0;
        repeat (3) step();
        check_zero("reset");

        // Static path: training word already on word boundaries
        reset = 1'b0; enable = 1'b1; mode[0] = 1; dly[0] = 0; mode[1] = 0;
        nv = 0;
        for (int c = 0; c < 24; c++) begin
            step();
            if (dout_valid) begin
                nv++;
                chk("static word", 32'(dout[7:0]), 32'h0B4);
            end
        end
        chk("static cadence", nv, 6);

        // Alignment on lane 0 (pattern 3 bits off), exhaustion on lane 1
        reset = 1'b1; step(); reset = 1'b0;
        mode[0] = 1; dly[0] = 3; mode[1] = 2;
        found = 0;
        for (int c = 0; c < 12 && found == 0; c++) begin
            step();
            if (dout_valid) found = 1;
        end
        chk("first word seen", found, 1);
        step();
        align_start = 1'b1; step(); align_start = 1'b0;
        s0 = 0; s1 = 0; lockw = -1; wsince = 0; bad = 0; lastv = -1; lk0 = 0;
        p0 = slip_offset[2:0]; p1 = slip_offset[5:3];
        for (int c = 0; c < 400 && !(locked[0] && align_fail[1]); c++) begin
            step();
            if (slip_offset[2:0] != p0) begin s0++; wsince = 0; end
            else if (dout_valid && !locked[0]) wsince++;
            if (slip_offset[5:3] != p1) s1++;
            p0 = slip_offset[2:0]; p1 = slip_offset[5:3];
            if (!lk0 && locked[0]) begin lk0 = 1; lockw = wsince; end
            if (dout_valid) begin
                if (lastv >= 0 && c - lastv != RATIO) bad++;
                lastv = c;
            end
        end
        chk("slips lane0", s0, 3);
        chk("offset lane0", 32'(slip_offset[2:0]), 32'd3);
        chk("locked lane0", 32'(locked[0]), 32'd1);
        chk("words to lock", lockw, 6);
        chk("slips lane1", s1, 8);
        chk("fail lane1", 32'(align_fail[1]), 32'd1);
        chk("locked lane1", 32'(locked[1]), 32'd0);
        chk("offset lane1 wrapped", 32'(slip_offset[5:3]), 32'd0);
        chk("cadence through wrap", bad, 0);

        // Enable gap in the middle of the third word
        reset = 1'b1; step(); reset = 1'b0;
        mode[0] = 0; mode[1] = 0; enable = 1'b1;
        nv = 0;
        for (int c = 0; c < 40 && nv < 2; c++) begin
            step();
            if (dout_valid) nv++;
        end
        step(); step();
        enable = 1'b0; gv = 0;
        repeat (5) begin
            step();
            if (dout_valid) gv++;
        end
        chk("valid in gap", gv, 0);
        enable = 1'b1; found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            step();
            if (dout_valid) found = 1;
        end
        chk("word after gap", found, 1);
        for (int l = 0; l < LANES; l++) begin
            for (int j = 0; j < W; j++) ew[W-1-j] = rnd[l][16 + j];
            chk("gap word", 32'(dout[l*W +: W]), 32'(ew));
        end

        // Reset while lane 1 is discarding after a slip
        reset = 1'b1; step(); reset = 1'b0;
        mode[0] = 0; mode[1] = 2;
        found = 0;
        for (int c = 0; c < 12 && found == 0; c++) begin
            step();
            if (dout_valid) found = 1;
        end
        step();
        align_start = 1'b1; step(); align_start = 1'b0;
        for (int c = 0; c < 60 && slip_offset[5:3] == 3'd0; c++) step();
        chk("slip before reset", 32'(slip_offset[5:3]), 32'd1);
        step();
        reset = 1'b1; step(); reset = 1'b0;
        check_zero("mid-slip reset");
        bad = 0;
        repeat (60) begin
            step();
            if (slip_offset != '0 || locked != '0 || align_fail != '0) bad++;
        end
        chk("idle after reset", bad, 0);

        // Random episodes
        for (int ep = 0; ep < 4; ep++) begin
            reset = 1'b1; align_start = 1'b0; enable = 1'b1; step(); reset = 1'b0;
            for (int l = 0; l < LANES; l++) begin
                mode[l] = $urandom_range(0, 3);
                if (mode[l] == 3) mode[l] = 1;
                dly[l] = $urandom_range(0, 7);
            end
            for (int c = 0; c < 300; c++) begin
                enable      = ($urandom_range(0, 9) != 0);
                align_start = ($urandom_range(0, 39) == 0) || c == 2;
                reset       = ($urandom_range(0, 299) == 0);
                step();
            end
            align_start = 1'b0; reset = 1'b0; enable = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i_ddr_deser_align.md
I_DDR_DESER_ALIGN -- requirements
Module: i_ddr_deser_align

Interface
REQ-001 SHALL have parameter LANES, default 2: number of independent DDR data lanes.
REQ-002 SHALL have parameter RATIO, default 4: clock cycles per output word; word width W = 2*RATIO bits.
REQ-003 SHALL have parameter TRAIN_PATTERN, default 8'hB4, width W: alignment training word.
REQ-004 SHALL have parameter LOCK_COUNT, default 4: consecutive matching words required for lock.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1: capture enable; low freezes all state except reset.
REQ-008 SHALL have port din_rise, input, LANES: per-lane bit captured on the rising half-cycle; earlier in time.
REQ-009 SHALL have port din_fall, input, LANES: per-lane bit captured on the falling half-cycle; later in time.
REQ-010 SHALL have port align_start, input, 1: one-cycle pulse that (re)starts alignment on all lanes.
REQ-011 SHALL have port dout, output, LANES*W: lane i occupies bits [i*W +: W]; MSB is the earliest bit.
REQ-012 SHALL have port dout_valid, output, 1: one-cycle strobe qualifying dout for all lanes.
REQ-013 SHALL have port locked, output, LANES: per-lane alignment achieved.
REQ-014 SHALL have port align_fail, output, LANES: per-lane alignment exhausted.
REQ-015 SHALL have port slip_offset, output, LANES*clog2(W): per-lane current bit offset.

Function
REQ-016 SHALL, while enable=1, append {din_rise[i], din_fall[i]} to a per-lane history of at least 2*W bits every cycle; history holds while enable=0.
REQ-017 SHALL keep a shared word counter 0..RATIO-1 that advances only when enable=1 and wraps to 0 after RATIO-1.
REQ-018 SHALL, on the edge where the counter equals RATIO-1 with enable=1, register dout and assert dout_valid for exactly the next cycle; dout holds its value between strobes.
REQ-019 SHALL form lane i word as the W contiguous bits ending slip_offset[i] bits before the newest sampled bit; offset 0 equals the last RATIO pairs.
REQ-020 SHALL run one alignment FSM per lane with states IDLE, CHECK, SLIP, LOCKED, FAIL.
REQ-021 SHALL move IDLE->CHECK on align_start; FSM evaluates only on dout_valid words.
REQ-022 SHALL, in CHECK, increment a match counter on word==TRAIN_PATTERN and enter LOCKED when it reaches LOCK_COUNT; on mismatch, clear the counter and enter SLIP.
REQ-023 SHALL, in SLIP, increment slip_offset modulo W (W-1 wraps to 0), then discard two whole words before returning to CHECK.
REQ-024 SHALL enter FAIL after W slips without lock (all offsets tried); FAIL holds until align_start or reset.
REQ-025 SHALL assert locked[i] only in LOCKED and align_fail[i] only in FAIL; slip_offset frozen in both.
REQ-026 SHALL, on align_start in any state, clear slip_offset, the match counter and the slip count, and enter CHECK the next cycle; align_start coincident with enable=0 is still honoured.
REQ-027 SHALL keep dout/dout_valid running in every FSM state; lanes align independently.

Reset
REQ-028 SHALL, on reset=1 at a rising edge, clear history, counter, dout, dout_valid, locked, align_fail and slip_offset to 0 and put every FSM in IDLE.
REQ-029 SHALL give reset priority over enable and align_start; reset mid-alignment abandons it with no further slips.

Verification
REQ-030 Static path: LANES=2, RATIO=4, enable=1, stream 8'hB4 on lane 0 at offset 0 -> dout_valid every 4th cycle, dout[7:0]=8'hB4.
REQ-031 Alignment: lane 0 pattern shifted by 3 bits, align_start pulse -> exactly 3 slips, slip_offset[0]=3, locked[0]=1 after 4 further matching words.
REQ-032 Failure: constant 8'h00 on lane 1 with align_start -> 8 slips, align_fail[1]=1, locked[1]=0, slip_offset[1]=0.
REQ-033 Enable gap: enable=0 for 5 cycles mid-word -> no dout_valid during gap; next word identical to the no-gap run.
REQ-034 Reset mid-SLIP: reset=1 for one cycle -> all outputs 0, FSM IDLE, no slip until next align_start.
REQ-035 Wrap: offset 7 plus one slip -> slip_offset=0, no glitch in dout_valid cadence.
